// File: rtl/tcp_arb_pkg.sv
// Shared types for the TCP transmit arbiter: FSM states, IP header layout, counter width.
package tcp_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        ABORT,
        DRAIN
    } arb_state_t;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] ip_len;
    } ip_hdr_t;

    localparam int unsigned HDR_WIDTH       = $bits(ip_hdr_t);
    localparam int unsigned STALL_CNT_WIDTH = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request bit after last_grant, with wrap.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_last_grant,
    output logic [$clog2(NUM_REQ)-1:0] o_grant,
    output logic                       o_any_req
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    int unsigned w_idx;

    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        w_idx     = 0;
        o_grant   = i_last_grant;
        o_any_req = |i_req;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            w_idx = 32'(i_last_grant) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (i_req[w_idx[IDX_W-1:0]]) begin
                o_grant = w_idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/tcp_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one IP transmit path between TCP stream
// engines, with a per-packet stall watchdog that aborts and drains stuck payloads.
module tcp_tx_arbiter #(
    parameter int unsigned NUM_STREAMS = 4,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned HDR_WIDTH   = tcp_arb_pkg::HDR_WIDTH,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [NUM_STREAMS-1:0]           i_enable,
    input  logic [NUM_STREAMS-1:0]           s_hdr_valid,
    output logic [NUM_STREAMS-1:0]           s_hdr_ready,
    input  logic [NUM_STREAMS*HDR_WIDTH-1:0] s_hdr_data,
    input  logic [NUM_STREAMS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_STREAMS-1:0]           s_axis_tvalid,
    output logic [NUM_STREAMS-1:0]           s_axis_tready,
    input  logic [NUM_STREAMS-1:0]           s_axis_tlast,
    output logic                             m_hdr_valid,
    input  logic                             m_hdr_ready,
    output logic [HDR_WIDTH-1:0]             m_hdr_data,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic                             m_axis_tuser,
    output logic [$clog2(NUM_STREAMS)-1:0]   o_grant,
    output logic                             o_busy,
    output logic                             o_abort
);

    import tcp_arb_pkg::*;

    localparam int unsigned GW = $clog2(NUM_STREAMS);
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_LAST = STALL_CNT_WIDTH'(TIMEOUT - 1);
    localparam bit WDOG_EN = (TIMEOUT != 0);

    arb_state_t                 r_state;
    logic [GW-1:0]              r_grant;
    logic [GW-1:0]              r_last_grant;
    logic [STALL_CNT_WIDTH-1:0] r_cnt;
    logic                       r_abort;

    logic [NUM_STREAMS-1:0] w_req;
    logic [GW-1:0]          w_arb_grant;
    logic                   w_any_req;
    logic                   w_src_hdr_valid;
    logic [HDR_WIDTH-1:0]   w_src_hdr_data;
    logic                   w_src_tvalid;
    logic                   w_src_tlast;
    logic [DATA_WIDTH-1:0]  w_src_tdata;
    logic                   w_fire;

    assign w_req           = s_hdr_valid & i_enable;
    assign w_src_hdr_valid = s_hdr_valid[r_grant];
    assign w_src_hdr_data  = s_hdr_data[32'(r_grant) * HDR_WIDTH +: HDR_WIDTH];
    assign w_src_tvalid    = s_axis_tvalid[r_grant];
    assign w_src_tlast     = s_axis_tlast[r_grant];
    assign w_src_tdata     = s_axis_tdata[32'(r_grant) * DATA_WIDTH +: DATA_WIDTH];

    // Fires on the stalled cycle that brings the counter up to TIMEOUT.
    assign w_fire = WDOG_EN && !w_src_tvalid && (r_cnt == STALL_LAST);

    rr_arbiter #(
        .NUM_REQ (NUM_STREAMS)
    ) u_rr_arbiter (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_arb_grant),
        .o_any_req    (w_any_req)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= GW'(NUM_STREAMS - 1);
            r_cnt        <= '0;
            r_abort      <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_arb_grant;
                        r_state <= HDR;
                    end
                end
                HDR: begin
                    if (w_src_hdr_valid && m_hdr_ready) begin
                        r_cnt   <= '0;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_src_tvalid) begin
                        r_cnt <= '0;
                        if (m_axis_tready && w_src_tlast) begin
                            r_last_grant <= r_grant;
                            r_state      <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_fire) begin
                            r_abort <= 1'b1;
                            r_state <= ABORT;
                        end
                    end
                end
                ABORT: begin
                    if (m_axis_tready) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_src_tvalid && w_src_tlast) begin
                        r_last_grant <= r_grant;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_hdr_ready   = '0;
        s_axis_tready = '0;
        m_hdr_valid   = 1'b0;
        m_hdr_data    = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        case (r_state)
            HDR: begin
                m_hdr_valid          = w_src_hdr_valid;
                m_hdr_data           = w_src_hdr_data;
                s_hdr_ready[r_grant] = m_hdr_ready;
            end
            DATA: begin
                m_axis_tvalid          = w_src_tvalid;
                m_axis_tdata           = w_src_tdata;
                m_axis_tlast           = w_src_tlast;
                s_axis_tready[r_grant] = m_axis_tready;
            end
            ABORT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = 1'b1;
            end
            DRAIN: begin
                s_axis_tready[r_grant] = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_grant = r_grant;
    assign o_busy  = (r_state != IDLE);
    assign o_abort = r_abort;

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Directed bench for tcp_tx_arbiter: reset, round-robin, backpressure, enable mask, watchdog.
module tb_tcp_tx_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   i_enable, s_hdr_valid, s_axis_tvalid, s_axis_tlast;
    logic [319:0] s_hdr_data;
    logic [31:0]  s_axis_tdata;
    logic         m_hdr_ready, m_axis_tready;

    logic [3:0] a_s_hdr_ready, a_s_axis_tready, b_s_hdr_ready, b_s_axis_tready;
    logic       a_m_hdr_valid, b_m_hdr_valid;
    logic [79:0] a_m_hdr_data, b_m_hdr_data;
    logic [7:0] a_m_axis_tdata, b_m_axis_tdata;
    logic       a_m_axis_tvalid, a_m_axis_tlast, a_m_axis_tuser;
    logic       b_m_axis_tvalid, b_m_axis_tlast, b_m_axis_tuser;
    logic [1:0] a_o_grant, b_o_grant;
    logic       a_o_busy, a_o_abort, b_o_busy, b_o_abort;

    // Selected DUT view: a = TIMEOUT 16, b = watchdog disabled.
    logic       use_b;
    logic [3:0] s_hdr_ready, s_axis_tready;
    logic       m_hdr_valid, m_axis_tvalid, m_axis_tlast, m_axis_tuser, o_busy, o_abort;
    logic [79:0] m_hdr_data;
    logic [7:0] m_axis_tdata;
    logic [1:0] o_grant;

    assign s_hdr_ready   = use_b ? b_s_hdr_ready   : a_s_hdr_ready;
    assign s_axis_tready = use_b ? b_s_axis_tready : a_s_axis_tready;
    assign m_hdr_valid   = use_b ? b_m_hdr_valid   : a_m_hdr_valid;
    assign m_hdr_data    = use_b ? b_m_hdr_data    : a_m_hdr_data;
    assign m_axis_tdata  = use_b ? b_m_axis_tdata  : a_m_axis_tdata;
    assign m_axis_tvalid = use_b ? b_m_axis_tvalid : a_m_axis_tvalid;
    assign m_axis_tlast  = use_b ? b_m_axis_tlast  : a_m_axis_tlast;
    assign m_axis_tuser  = use_b ? b_m_axis_tuser  : a_m_axis_tuser;
    assign o_grant       = use_b ? b_o_grant       : a_o_grant;
    assign o_busy        = use_b ? b_o_busy        : a_o_busy;
    assign o_abort       = use_b ? b_o_abort       : a_o_abort;

    tcp_tx_arbiter #(.NUM_STREAMS(4), .DATA_WIDTH(8), .HDR_WIDTH(80), .TIMEOUT(16)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(i_enable),
        .s_hdr_valid(s_hdr_valid), .s_hdr_ready(a_s_hdr_ready), .s_hdr_data(s_hdr_data),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(a_s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_hdr_valid(a_m_hdr_valid), .m_hdr_ready(m_hdr_ready), .m_hdr_data(a_m_hdr_data),
        .m_axis_tdata(a_m_axis_tdata), .m_axis_tvalid(a_m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(a_m_axis_tlast),
        .m_axis_tuser(a_m_axis_tuser), .o_grant(a_o_grant), .o_busy(a_o_busy),
        .o_abort(a_o_abort)
    );

    tcp_tx_arbiter #(.NUM_STREAMS(4), .DATA_WIDTH(8), .HDR_WIDTH(80), .TIMEOUT(0)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(i_enable),
        .s_hdr_valid(s_hdr_valid), .s_hdr_ready(b_s_hdr_ready), .s_hdr_data(s_hdr_data),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(b_s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_hdr_valid(b_m_hdr_valid), .m_hdr_ready(m_hdr_ready), .m_hdr_data(b_m_hdr_data),
        .m_axis_tdata(b_m_axis_tdata), .m_axis_tvalid(b_m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(b_m_axis_tlast),
        .m_axis_tuser(b_m_axis_tuser), .o_grant(b_o_grant), .o_busy(b_o_busy),
        .o_abort(b_o_abort)
    );

    always #5 clk = ~clk;

    typedef struct { int g; logic [79:0] h; int c; } hdr_rec_t;
    typedef struct { int g; logic [7:0] d; logic l; logic u; int c; } beat_rec_t;

    hdr_rec_t  hdr_log[$];
    beat_rec_t beat_log[$];

    int src_pkts[4], src_beats[4], src_sent[4], hold_at[4];
    bit src_in_pkt[4], hold_en[4];
    bit tready_toggle;
    int cyc, viol, abort_cnt, abort_cyc;
    int n_pass = 0, n_total = 0;

    function automatic logic [79:0] hdr_of(input int i, input int len);
        return {32'h0A00_0000 + 32'(i), 32'hC0A8_0100 + 32'(i), 16'(len)};
    endfunction

    task automatic drive_src();
        for (int i = 0; i < 4; i++) begin
            s_hdr_valid[i]            = (src_pkts[i] > 0) && !src_in_pkt[i];
            s_hdr_data[i*80 +: 80]    = hdr_of(i, src_beats[i]);
            s_axis_tvalid[i]          = src_in_pkt[i] && !(hold_en[i] && src_sent[i] == hold_at[i]);
            s_axis_tdata[i*8 +: 8]    = {2'(i), 6'(src_sent[i])};
            s_axis_tlast[i]           = src_in_pkt[i] && (src_sent[i] == src_beats[i] - 1);
        end
        m_hdr_ready   = 1'b1;
        m_axis_tready = tready_toggle ? cyc[0] : 1'b1;
    endtask

    // One clock: drive sources, observe the shared side, then retire source handshakes.
    task automatic step();
        logic [3:0] hdr_hs, beat_hs;
        drive_src();
        #1;
        hdr_hs  = s_hdr_valid & s_hdr_ready;
        beat_hs = s_axis_tvalid & s_axis_tready;
        if (m_hdr_valid && m_hdr_ready)
            hdr_log.push_back('{g: int'(o_grant), h: m_hdr_data, c: cyc});
        if (m_axis_tvalid && m_axis_tready)
            beat_log.push_back('{g: int'(o_grant), d: m_axis_tdata, l: m_axis_tlast,
                                 u: m_axis_tuser, c: cyc});
        if (o_abort) begin
            abort_cnt++;
            abort_cyc = cyc;
        end
        for (int i = 0; i < 4; i++)
            if ((s_hdr_ready[i] || s_axis_tready[i]) && (!o_busy || i != int'(o_grant))) viol++;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (hdr_hs[i]) begin
                src_in_pkt[i] = 1'b1;
                src_sent[i]   = 0;
            end
            if (beat_hs[i]) begin
                if (src_sent[i] == src_beats[i] - 1) begin
                    src_in_pkt[i] = 1'b0;
                    src_pkts[i]--;
                end else begin
                    src_sent[i]++;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_logs();
        hdr_log.delete();
        beat_log.delete();
        viol      = 0;
        abort_cnt = 0;
        abort_cyc = -1;
        cyc       = 0;
    endtask

    task automatic reset_all();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src_pkts[i] = 0; src_beats[i] = 1; src_sent[i] = 0;
            src_in_pkt[i] = 1'b0; hold_en[i] = 1'b0; hold_at[i] = 0;
        end
        s_hdr_valid = '0; s_axis_tvalid = '0; s_axis_tlast = '0;
        s_hdr_data = '0; s_axis_tdata = '0;
        i_enable = 4'hF; m_hdr_ready = 1'b1; m_axis_tready = 1'b1;
        tready_toggle = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        #1;
        n_total++; if (o_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", o_busy); else n_pass++;
        n_total++; if (o_grant !== 2'd0) $display("FAIL rst_grant: got %0d want 0", o_grant); else n_pass++;
        n_total++; if ({m_hdr_valid, m_axis_tvalid, s_hdr_ready, s_axis_tready} !== 10'd0)
            $display("FAIL rst_outputs: got %b want 0",
                     {m_hdr_valid, m_axis_tvalid, s_hdr_ready, s_axis_tready});
        else n_pass++;
        reset_all();
        src_pkts[1] = 1; src_beats[1] = 10;
        repeat (5) step();
        drive_src();
        #1;
        n_total++; if ({m_axis_tvalid, o_grant} !== 3'b1_01)
            $display("FAIL mid_pkt: got tvalid=%b grant=%0d want tvalid=1 grant=1",
                     m_axis_tvalid, o_grant);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if ({m_axis_tvalid, m_axis_tlast, m_hdr_valid, s_axis_tready, s_hdr_ready} !== 11'd0)
            $display("FAIL async_rst_outputs: got %b want 0",
                     {m_axis_tvalid, m_axis_tlast, m_hdr_valid, s_axis_tready, s_hdr_ready});
        else n_pass++;
        n_total++; if ({o_grant, o_busy} !== 3'd0)
            $display("FAIL async_rst_grant: got grant=%0d busy=%b want 0/0", o_grant, o_busy);
        else n_pass++;
        reset_all();
    endtask

    task automatic test_round_robin();
        int exp_rr[5] = '{0, 1, 2, 3, 0};
        logic [7:0] exp_d;
        src_pkts = '{2, 1, 1, 1};
        src_beats = '{3, 3, 3, 3};
        for (int k = 0; k < 100 && beat_log.size() < 15; k++) step();
        n_total++; if (beat_log.size() != 15 || hdr_log.size() != 5)
            $display("FAIL rr_counts: got beats=%0d hdrs=%0d want 15/5", beat_log.size(), hdr_log.size());
        else n_pass++;
        n_total++; if (hdr_log.size() > 0 && hdr_log[0].c != 1)
            $display("FAIL rr_first_hdr_cycle: got %0d want 1", hdr_log[0].c);
        else n_pass++;
        for (int k = 0; k < hdr_log.size() && k < 5; k++) begin
            n_total++; if (hdr_log[k].g != exp_rr[k] || hdr_log[k].h !== hdr_of(exp_rr[k], 3))
                $display("FAIL rr_hdr[%0d]: got grant=%0d hdr=%h want grant=%0d hdr=%h", k,
                         hdr_log[k].g, hdr_log[k].h, exp_rr[k], hdr_of(exp_rr[k], 3));
            else n_pass++;
        end
        for (int j = 0; j < beat_log.size() && j < 15; j++) begin
            exp_d = {2'(exp_rr[j/3]), 6'(j % 3)};
            n_total++; if (beat_log[j].d !== exp_d || beat_log[j].l !== (j % 3 == 2) || beat_log[j].u !== 1'b0)
                $display("FAIL rr_beat[%0d]: got d=%h l=%b u=%b want d=%h l=%b u=0", j,
                         beat_log[j].d, beat_log[j].l, beat_log[j].u, exp_d, (j % 3 == 2));
            else n_pass++;
        end
        for (int k = 1; k < 5 && 3 * k < beat_log.size(); k++) begin
            n_total++; if (beat_log[3*k].c - beat_log[3*k-1].c != 3)
                $display("FAIL rr_gap[%0d]: got %0d want 3", k, beat_log[3*k].c - beat_log[3*k-1].c);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d;
        clear_logs();
        src_pkts[2] = 1; src_beats[2] = 64;
        tready_toggle = 1'b1;
        for (int k = 0; k < 400 && beat_log.size() < 64; k++) step();
        tready_toggle = 1'b0;
        n_total++; if (beat_log.size() != 64)
            $display("FAIL bp_count: got %0d want 64", beat_log.size());
        else n_pass++;
        for (int j = 0; j < beat_log.size(); j++) begin
            exp_d = {2'd2, 6'(j)};
            n_total++; if (beat_log[j].d !== exp_d || beat_log[j].l !== (j == 63) || beat_log[j].u !== 1'b0)
                $display("FAIL bp_beat[%0d]: got d=%h l=%b u=%b want d=%h l=%b u=0", j,
                         beat_log[j].d, beat_log[j].l, beat_log[j].u, exp_d, (j == 63));
            else n_pass++;
        end
        n_total++; if (abort_cnt != 0) $display("FAIL bp_abort: got %0d want 0", abort_cnt); else n_pass++;
        n_total++; if (viol != 0) $display("FAIL bp_foreign_ready: got %0d want 0", viol); else n_pass++;
    endtask

    task automatic test_enable_mask();
        int exp_en[5] = '{0, 2, 0, 2, 0};
        clear_logs();
        src_pkts = '{3, 2, 3, 2};
        src_beats = '{4, 4, 4, 4};
        i_enable = 4'b0101;
        for (int k = 0; k < 100 && hdr_log.size() < 4; k++) step();
        repeat (2) step();
        i_enable = 4'b0001;
        for (int k = 0; k < 100 && beat_log.size() < 20; k++) step();
        repeat (6) step();
        n_total++; if (hdr_log.size() != 5 || beat_log.size() != 20)
            $display("FAIL en_counts: got hdrs=%0d beats=%0d want 5/20", hdr_log.size(), beat_log.size());
        else n_pass++;
        for (int k = 0; k < hdr_log.size() && k < 5; k++) begin
            n_total++; if (hdr_log[k].g != exp_en[k])
                $display("FAIL en_grant[%0d]: got %0d want %0d", k, hdr_log[k].g, exp_en[k]);
            else n_pass++;
        end
        for (int j = 12; j < 16 && j < beat_log.size(); j++) begin
            n_total++; if (beat_log[j].g != 2 || beat_log[j].l !== (j == 15))
                $display("FAIL en_inflight[%0d]: got g=%0d l=%b want g=2 l=%b", j,
                         beat_log[j].g, beat_log[j].l, (j == 15));
            else n_pass++;
        end
        n_total++; if (o_busy !== 1'b0) $display("FAIL en_idle: got busy=%b want 0", o_busy); else n_pass++;
        n_total++; if (viol != 0) $display("FAIL en_foreign_ready: got %0d want 0", viol); else n_pass++;
    endtask

    task automatic test_watchdog();
        reset_all();
        src_pkts[1] = 1; src_beats[1] = 10; hold_en[1] = 1'b1; hold_at[1] = 5;
        src_pkts[2] = 1; src_beats[2] = 2;
        for (int k = 0; k < 100 && abort_cnt == 0; k++) step();
        repeat (3) step();
        n_total++; if (abort_cnt != 1) $display("FAIL wd_pulse_count: got %0d want 1", abort_cnt); else n_pass++;
        n_total++; if (beat_log.size() != 6)
            $display("FAIL wd_beats_at_abort: got %0d want 6", beat_log.size());
        else n_pass++;
        if (beat_log.size() >= 6) begin
            n_total++; if (abort_cyc != beat_log[4].c + 17)
                $display("FAIL wd_timing: got cycle %0d want %0d", abort_cyc, beat_log[4].c + 17);
            else n_pass++;
            n_total++; if ({beat_log[5].d, beat_log[5].l, beat_log[5].u} !== 10'b0000_0000_11 ||
                           beat_log[5].g != 1 || beat_log[5].c != abort_cyc)
                $display("FAIL wd_abort_beat: got g=%0d d=%h l=%b u=%b c=%0d want g=1 d=00 l=1 u=1 c=%0d",
                         beat_log[5].g, beat_log[5].d, beat_log[5].l, beat_log[5].u, beat_log[5].c,
                         abort_cyc);
            else n_pass++;
        end
        hold_en[1] = 1'b0;
        for (int k = 0; k < 100 && beat_log.size() < 8; k++) step();
        repeat (5) step();
        n_total++; if (beat_log.size() != 8 || hdr_log.size() != 2)
            $display("FAIL wd_after_drain: got beats=%0d hdrs=%0d want 8/2", beat_log.size(), hdr_log.size());
        else n_pass++;
        if (beat_log.size() >= 8 && hdr_log.size() >= 2) begin
            n_total++; if (hdr_log[1].g != 2 || beat_log[6].d !== 8'h80 || beat_log[7].d !== 8'h81 ||
                           beat_log[7].l !== 1'b1 || beat_log[7].u !== 1'b0)
                $display("FAIL wd_next_pkt: got g=%0d d=%h,%h l=%b u=%b want g=2 d=80,81 l=1 u=0",
                         hdr_log[1].g, beat_log[6].d, beat_log[7].d, beat_log[7].l, beat_log[7].u);
            else n_pass++;
        end
        n_total++; if (src_pkts[1] != 0 || src_in_pkt[1])
            $display("FAIL wd_drained: got pkts=%0d in_pkt=%b want 0/0", src_pkts[1], src_in_pkt[1]);
        else n_pass++;
    endtask

    task automatic test_no_timeout();
        reset_all();
        use_b = 1'b1;
        src_pkts[1] = 1; src_beats[1] = 4; hold_en[1] = 1'b1; hold_at[1] = 2;
        for (int k = 0; k < 20 && beat_log.size() < 2; k++) step();
        repeat (5000) step();
        n_total++; if (abort_cnt != 0 || beat_log.size() != 2)
            $display("FAIL nt_stall: got aborts=%0d beats=%0d want 0/2", abort_cnt, beat_log.size());
        else n_pass++;
        n_total++; if ({o_busy, o_grant} !== 3'b1_01)
            $display("FAIL nt_holding: got busy=%b grant=%0d want 1/1", o_busy, o_grant);
        else n_pass++;
        hold_en[1] = 1'b0;
        for (int k = 0; k < 50 && beat_log.size() < 4; k++) step();
        step();
        n_total++; if (beat_log.size() != 4) $display("FAIL nt_count: got %0d want 4", beat_log.size());
        else n_pass++;
        for (int j = 0; j < beat_log.size(); j++) begin
            n_total++; if (beat_log[j].d !== {2'd1, 6'(j)} || beat_log[j].l !== (j == 3) || beat_log[j].u !== 1'b0)
                $display("FAIL nt_beat[%0d]: got d=%h l=%b u=%b want d=%h l=%b u=0", j,
                         beat_log[j].d, beat_log[j].l, beat_log[j].u, {2'd1, 6'(j)}, (j == 3));
            else n_pass++;
        end
        n_total++; if (o_busy !== 1'b0 || abort_cnt != 0)
            $display("FAIL nt_done: got busy=%b aborts=%0d want 0/0", o_busy, abort_cnt);
        else n_pass++;
        use_b = 1'b0;
    endtask

    initial begin
        use_b = 1'b0;
        rst_n = 1'b0;
        s_hdr_valid = '0; s_axis_tvalid = '0; s_axis_tlast = '0;
        s_hdr_data = '0; s_axis_tdata = '0;
        i_enable = 4'hF; m_hdr_ready = 1'b1; m_axis_tready = 1'b1;
        tready_toggle = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src_pkts[i] = 0; src_beats[i] = 1; src_sent[i] = 0;
            src_in_pkt[i] = 1'b0; hold_en[i] = 1'b0; hold_at[i] = 0;
        end
        clear_logs();
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_backpressure();
        test_enable_mask();
        test_watchdog();
        test_no_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
